// File: rtl/regfile_x64_pkg.sv
// Shared constants for the LEGv8 architectural register file.
package regfile_pkg;
  localparam int          DATA_W   = 64;
  localparam int          ADDR_W   = 5;
  localparam int          NUM_REGS = 32;
  localparam logic [4:0]  XZR_IDX  = 5'd31;
endpackage

// File: rtl/regfile_x64_if.sv
// Decode/writeback access bundle for regfile_x64: one write port and two read ports.
interface regfile_x64_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile_x64_mux.sv
// 1-bit selection primitives; mux32_1 is composed from two mux16_1 halves and a mux2_1.
module mux2_1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module mux16_1 (
  input  logic [15:0] d,
  input  logic [3:0]  sel,
  output logic        y
);
  assign y = d[sel];
endmodule

module mux32_1 (
  input  logic [31:0] d,
  input  logic [4:0]  sel,
  output logic        y
);
  logic y_lo;
  logic y_hi;

  mux16_1 u_lo (.d(d[15:0]),  .sel(sel[3:0]), .y(y_lo));
  mux16_1 u_hi (.d(d[31:16]), .sel(sel[3:0]), .y(y_hi));
  mux2_1  u_top (.d0(y_lo), .d1(y_hi), .sel(sel[4]), .y(y));
endmodule

// File: rtl/regfile_x64.sv
// 32 x 64-bit LEGv8 register file, X31 = XZR. Two combinational reads, one synchronous write.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_x64 #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input logic          clk,
  input logic          reset,
  regfile_x64_if.slave rf
);
  import regfile_pkg::*;

  localparam int NREG = 1 << ADDR_W;

  // X0..X30 only; X31 has no storage and its decoder output is not built.
  logic [DATA_W-1:0] regs [0:NREG-2];
  logic [NREG-2:0]   we_dec;
  logic [DATA_W-1:0] rd1_tree;
  logic [DATA_W-1:0] rd2_tree;

  always_comb begin
    we_dec = '0;
    for (int i = 0; i < NREG - 1; i++) begin
      we_dec[i] = rf.RegWrite && (rf.WriteRegister == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG - 1; i++) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (we_dec[i]) begin
        regs[i] <= rf.WriteData;
      end
    end
  end

  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    logic [NREG-1:0] col;

    // Top input of each tree is tied low so index 31 reads zero.
    always_comb begin
      col = '0;
      for (int i = 0; i < NREG - 1; i++) begin
        col[i] = regs[i][b];
      end
    end

    mux32_1 u_rd1 (.d(col), .sel(rf.ReadRegister1), .y(rd1_tree[b]));
    mux32_1 u_rd2 (.d(col), .sel(rf.ReadRegister2), .y(rd2_tree[b]));
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  assign byp1 = rf.RegWrite & ~reset & (rf.WriteRegister == rf.ReadRegister1)
              & (rf.ReadRegister1 != XZR_IDX);
  assign byp2 = rf.RegWrite & ~reset & (rf.WriteRegister == rf.ReadRegister2)
              & (rf.ReadRegister2 != XZR_IDX);

  assign rf.ReadData1 = byp1 ? rf.WriteData : rd1_tree;
  assign rf.ReadData2 = byp2 ? rf.WriteData : rd2_tree;
`else
  assign rf.ReadData1 = rd1_tree;
  assign rf.ReadData2 = rd2_tree;
`endif

endmodule

// File: tb/tb_regfile_x64.sv
// Directed bench for regfile_x64: reset, full write/read sweep, XZR, write disable,
// read/write collision (expectation follows REGFILE_BYPASS_EN) and mid-run reset.
module tb_regfile_x64;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  regfile_x64_if rf_if ();

  regfile_x64 dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int k);
    return (k == 31) ? 64'h0 : (64'h1111_0000_0000_0000 + 64'(k));
  endfunction

  initial begin
    errors = 0;
    checks = 0;

    // Reset beats a simultaneous write to X3.
    reset                  = 1'b1;
    rf_if.RegWrite         = 1'b1;
    rf_if.WriteRegister    = 5'd3;
    rf_if.WriteData        = 64'hDEAD;
    rf_if.ReadRegister1    = 5'd0;
    rf_if.ReadRegister2    = 5'd0;
    tick();
    reset          = 1'b0;
    rf_if.RegWrite = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rf_if.ReadRegister1 = 5'(k);
      rf_if.ReadRegister2 = 5'(k);
      #1;
      chk($sformatf("rst_rd1_x%0d", k), rf_if.ReadData1, 64'h0);
      chk($sformatf("rst_rd2_x%0d", k), rf_if.ReadData2, 64'h0);
    end

    // Write every architectural register with a distinct pattern.
    rf_if.ReadRegister1 = 5'd31;
    rf_if.ReadRegister2 = 5'd31;
    for (int k = 0; k < 31; k++) begin
      rf_if.RegWrite      = 1'b1;
      rf_if.WriteRegister = 5'(k);
      rf_if.WriteData     = pat(k);
      tick();
    end
    rf_if.RegWrite = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rf_if.ReadRegister1 = 5'(k);
      rf_if.ReadRegister2 = 5'(31 - k);
      #1;
      chk($sformatf("sweep_rd1_x%0d", k), rf_if.ReadData1, pat(k));
      chk($sformatf("sweep_rd2_x%0d", 31 - k), rf_if.ReadData2, pat(31 - k));
    end

    // Writes to XZR vanish, even in the cycle they are presented.
    rf_if.RegWrite      = 1'b1;
    rf_if.WriteRegister = 5'd31;
    rf_if.WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
    rf_if.ReadRegister1 = 5'd31;
    rf_if.ReadRegister2 = 5'd31;
    #1;
    chk("xzr_same_cycle_rd1", rf_if.ReadData1, 64'h0);
    chk("xzr_same_cycle_rd2", rf_if.ReadData2, 64'h0);
    tick();
    rf_if.RegWrite = 1'b0;
    #1;
    chk("xzr_rd1", rf_if.ReadData1, 64'h0);
    chk("xzr_rd2", rf_if.ReadData2, 64'h0);
    rf_if.ReadRegister1 = 5'd30;
    #1;
    chk("xzr_x30_intact", rf_if.ReadData1, 64'h1111_0000_0000_001E);

    // RegWrite low must not disturb X5.
    rf_if.RegWrite      = 1'b0;
    rf_if.WriteRegister = 5'd5;
    rf_if.WriteData     = 64'h55;
    tick();
    rf_if.ReadRegister2 = 5'd5;
    #1;
    chk("wdis_x5", rf_if.ReadData2, 64'h1111_0000_0000_0005);

    // Same-index read and write on port 1.
    rf_if.RegWrite      = 1'b1;
    rf_if.WriteRegister = 5'd7;
    rf_if.WriteData     = 64'hABCD;
    rf_if.ReadRegister1 = 5'd7;
    rf_if.ReadRegister2 = 5'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("coll_before_edge", rf_if.ReadData1, 64'hABCD);
`else
    chk("coll_before_edge", rf_if.ReadData1, 64'h1111_0000_0000_0007);
`endif
    chk("coll_other_port", rf_if.ReadData2, 64'h1111_0000_0000_0006);
    tick();
    rf_if.RegWrite = 1'b0;
    #1;
    chk("coll_after_edge", rf_if.ReadData1, 64'hABCD);

    // Mid-run reset aborts a simultaneous write to X9.
    rf_if.RegWrite      = 1'b1;
    rf_if.WriteRegister = 5'd9;
    rf_if.WriteData     = 64'h99;
    tick();
    rf_if.RegWrite      = 1'b0;
    rf_if.ReadRegister1 = 5'd9;
    rf_if.ReadRegister2 = 5'd7;
    #1;
    chk("mid_x9_loaded", rf_if.ReadData1, 64'h99);
    reset               = 1'b1;
    rf_if.RegWrite      = 1'b1;
    rf_if.WriteData     = 64'h42;
    #1;
    chk("mid_rst_no_bypass", rf_if.ReadData1, 64'h99);
    tick();
    reset          = 1'b0;
    rf_if.RegWrite = 1'b0;
    #1;
    chk("mid_rst_x9", rf_if.ReadData1, 64'h0);
    chk("mid_rst_x7", rf_if.ReadData2, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
